piso_shift_tx: RTL and testbench

Parallel-in serial-out transmitter. It is the sending end for the team's 4-bit SIPO receiver, which shifts right and inserts at the MSB. The block accepts a parallel word over a valid/ready handshake and drives it out one bit per clock. With default parameters, a downstream SIPO clocked on the same edge holds the original word after WIDTH shifts. It supports back-to-back words with no idle gap, for streaming links between blocks.

---
 rtl/piso_shift_tx.sv | 96 +++++++++
 tb/tb_piso_shift_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and
// drives it out one bit per clock, supporting back-to-back words.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_s;
    logic             accept_s;
    logic [WIDTH-1:0] shifted_s;

    // The output end of the shift register is fixed by LSB_FIRST; zero fill
    // guarantees the register is all-zero once a word has fully drained.
    assign shifted_s = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                                 : {shift_q[WIDTH-2:0], 1'b0};

    assign last_s     = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign load_ready = (state_q == ST_IDLE) || last_s;
    assign accept_s   = load_valid && load_ready;

    assign ser_valid  = (state_q == ST_SHIFT);
    assign done       = last_s;
    assign ser_out    = (state_q == ST_SHIFT) &&
                        (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1]);

    // Next-state logic for FSM, shift register and bit counter
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_d = load_data;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (accept_s) begin
                    // Reload on the last-bit cycle keeps the stream gapless.
                    shift_d = load_data;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else if (last_s) begin
                    shift_d = shifted_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    shift_d = shifted_s;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = {WIDTH{1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a 4-bit LSB-first instance checked against a
// cycle-schedule reference model with a loopback SIPO, plus an 8-bit MSB-first instance.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       rst4, rst8;
    logic       lv4, lv8;
    logic [3:0] ld4;
    logic [7:0] ld8;
    logic       rdy4, so4, sv4, dn4;
    logic       rdy8, so8, sv8, dn8;
    logic [3:0] rx_q;

    int n_pass = 0;
    int n_total = 0;

    // Reference schedule for the 4-bit instance, indexed by cycle number
    localparam int NCYC = 2048;
    bit exp_v [NCYC];
    bit exp_b [NCYC];
    bit exp_d [NCYC];
    int cyc = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst4), .load_valid(lv4), .load_data(ld4),
        .load_ready(rdy4), .ser_out(so4), .ser_valid(sv4), .done(dn4)
    );

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst8), .load_valid(lv8), .load_data(ld8),
        .load_ready(rdy8), .ser_out(so8), .ser_valid(sv8), .done(dn8)
    );

    // Downstream 4-bit receiver: shifts right, inserts at the MSB
    always_ff @(posedge clk or posedge rst4) begin
        if (rst4)     rx_q <= 4'h0;
        else if (sv4) rx_q <= {so4, rx_q[3:1]};
        else          rx_q <= rx_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic bit model_ready(input int c);
        return !exp_v[c] || exp_d[c];
    endfunction

    // One cycle of the 4-bit instance: check outputs, drive inputs, update model
    task automatic step4(input logic v, input logic [3:0] d);
        @(negedge clk);
        check("ser_valid", sv4, exp_v[cyc]);
        check("ser_out", so4, exp_b[cyc]);
        check("done", dn4, exp_d[cyc]);
        check("load_ready", rdy4, model_ready(cyc));
        lv4 = v;
        ld4 = d;
        if (v && model_ready(cyc)) begin
            for (int k = 0; k < 4; k++) begin
                exp_v[cyc + 1 + k] = 1'b1;
                exp_b[cyc + 1 + k] = d[k];
                exp_d[cyc + 1 + k] = (k == 3);
            end
        end
        cyc++;
    endtask

    task automatic reset4();
        @(negedge clk);
        rst4 = 1'b1;
        lv4  = 1'b1;
        ld4  = 4'($urandom);
        #1;
        check("rst ser_out", so4, 1'b0);
        check("rst ser_valid", sv4, 1'b0);
        check("rst done", dn4, 1'b0);
        check("rst load_ready", rdy4, 1'b1);
        for (int c = cyc; c < NCYC; c++) begin
            exp_v[c] = 1'b0;
            exp_b[c] = 1'b0;
            exp_d[c] = 1'b0;
        end
        cyc++;
        @(negedge clk);
        check("rst held ser_valid", sv4, 1'b0);
        rst4 = 1'b0;
        lv4  = 1'b0;
        cyc++;
    endtask

    task automatic send_loop(input logic [3:0] w);
        step4(1'b1, w);
        repeat (5) step4(1'b0, 4'($urandom));
        check("loopback rx", rx_q, w);
    endtask

    task automatic step8(input logic v, input logic [7:0] d,
                         input logic ev, input logic eb, input logic ed, input logic er);
        @(negedge clk);
        check("w8 ser_valid", sv8, ev);
        check("w8 ser_out", so8, eb);
        check("w8 done", dn8, ed);
        check("w8 load_ready", rdy8, er);
        lv8 = v;
        ld8 = d;
    endtask

    initial begin
        logic [7:0] w8;
        rst4 = 1'b1; rst8 = 1'b1;
        lv4 = 1'b0; lv8 = 1'b0; ld4 = 4'h0; ld8 = 8'h00;
        #1;
        check("init ser_valid", sv4, 1'b0);
        check("init load_ready", rdy4, 1'b1);
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;

        // Single word 1011, then idle
        step4(1'b1, 4'b1011);
        repeat (6) step4(1'b0, 4'($urandom));

        // Back-to-back A then F (F held until accepted)
        step4(1'b1, 4'hA);
        repeat (4) step4(1'b1, 4'hF);
        repeat (6) step4(1'b0, 4'h0);

        // Loopback into the receiver
        send_loop(4'h6);
        send_loop(4'h0);
        send_loop(4'hF);
        send_loop(4'h9);

        // Busy ignore: 3 offered during bit 1 of C is dropped
        step4(1'b1, 4'hC);
        step4(1'b0, 4'h0);
        step4(1'b1, 4'h3);
        step4(1'b0, 4'h3);
        repeat (4) step4(1'b0, 4'h0);

        // Mid-word reset with load_valid high
        step4(1'b1, 4'h7);
        step4(1'b0, 4'h0);
        step4(1'b0, 4'h0);
        reset4();
        repeat (6) step4(1'b0, 4'($urandom));

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step4(1'($urandom_range(0, 1)), 4'($urandom));
        repeat (6) step4(1'b0, 4'h0);

        // 8-bit MSB-first: 1000_0001
        w8 = 8'b1000_0001;
        step8(1'b1, w8, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            step8(1'b0, 8'h00, 1'b1, w8[7 - k], k == 7, k == 7);
        step8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset at bit 3 of a word, then 8'hFF sends eight ones
        step8(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        w8 = 8'h5A;
        for (int k = 0; k < 3; k++)
            step8(1'b0, 8'h00, 1'b1, w8[7 - k], 1'b0, 1'b0);
        @(negedge clk);
        rst8 = 1'b1;
        lv8  = 1'b1;
        #1;
        check("w8 rst ser_valid", sv8, 1'b0);
        check("w8 rst ser_out", so8, 1'b0);
        check("w8 rst load_ready", rdy8, 1'b1);
        @(negedge clk);
        rst8 = 1'b0;
        lv8  = 1'b0;
        step8(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            step8(1'b0, 8'h00, 1'b1, 1'b1, k == 7, k == 7);
        step8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
